// File: rtl/cpu_issue_pkg.sv
// Shared definitions for the CPU instruction issuer.
//   issue_state_t : issuer FSM states
//   OP_* / ALU_*  : instruction field constants in cpu encoding
//   mk_instr      : builds a 16-bit word from {opcode, op, rn, low8}, where
//                   low8 is either an 8-bit immediate or {rd, sh, rm}
package cpu_issue_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    SETTLE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } issue_state_t;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [2:0] opcode,
                                                  input logic [1:0] op,
                                                  input logic [2:0] rn,
                                                  input logic [7:0] low8);
    return {opcode, op, rn, low8};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding instructions waiting to be issued.
//   clk, reset : clock and synchronous active-high reset (pointers only)
//   push, din  : write din at the tail; ignored while full
//   pop, dout  : dout shows the head combinationally; pop advances it
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the address bits are equal.
module instr_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_instr_issuer.sv
// Feeds queued instructions one at a time to the cpu core and reports each
// completion.
//   instr_valid/instr_data/instr_ready : host push interface into the FIFO
//   cpu_in/cpu_load/cpu_s              : registered drive of cpu.in/load/s
//   cpu_w/cpu_out/cpu_nvz              : cpu wait flag, datapath out, flags
//   result_valid/result_data/result_nvz: one-cycle completion pulse + capture
//   done_count                         : completed instructions (wraps)
//   busy                               : FSM active or FIFO non-empty
//   timeout_err                        : sticky, set when WAIT gives up
module cpu_instr_issuer
  import cpu_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        instr_ready,
  output logic [15:0] cpu_in,
  output logic        cpu_load,
  output logic        cpu_s,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic [2:0]  cpu_nvz,
  output logic        result_valid,
  output logic [15:0] result_data,
  output logic [2:0]  result_nvz,
  output logic [15:0] done_count,
  output logic        busy,
  output logic        timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  issue_state_t      state;
  issue_state_t      state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [15:0]       fifo_dout;

  instr_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(16)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (instr_valid),
    .din  (instr_data),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign instr_ready = !fifo_full;
  assign busy        = (state != IDLE) || !fifo_empty;
  // The head is consumed on the edge that enters LOAD, in step with cpu_in.
  assign fifo_pop    = (state == IDLE) && (state_nxt == LOAD);

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:   if (!fifo_empty && cpu_w) state_nxt = LOAD;
      LOAD:   state_nxt = START;
      START:  state_nxt = SETTLE;
      // cpu_w is still high here while the cpu leaves its wait state.
      SETTLE: state_nxt = WAIT;
      WAIT: begin
        if (cpu_w) begin
          state_nxt = DONE;
        end else if (tmo_cnt == CNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up
  // exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      cpu_in       <= '0;
      cpu_load     <= 1'b0;
      cpu_s        <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_nvz   <= '0;
      done_count   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cpu_load     <= (state_nxt == LOAD);
      cpu_s        <= (state_nxt == START);
      result_valid <= (state_nxt == DONE);

      if (fifo_pop) cpu_in <= fifo_dout;

      if (state == SETTLE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT && !cpu_w && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (tmo_hit) timeout_err <= 1'b1;

      // Capture on the WAIT->DONE edge so the values are present during DONE.
      if (state == WAIT && cpu_w) begin
        result_data <= cpu_out;
        result_nvz  <= cpu_nvz;
        done_count  <= done_count + 16'd1;
      end
    end
  end

endmodule
